// File: rtl/ahblite_pkg.sv
// Shared AHB-Lite encodings and the SRAM slave FSM state type.
package ahblite_pkg;

  localparam logic [1:0] TransIdle   = 2'b00;
  localparam logic [1:0] TransBusy   = 2'b01;
  localparam logic [1:0] TransNonseq = 2'b10;
  localparam logic [1:0] TransSeq    = 2'b11;

  localparam logic [1:0] RespOkay  = 2'b00;
  localparam logic [1:0] RespError = 2'b01;

  localparam logic [2:0] SizeByte = 3'b000;
  localparam logic [2:0] SizeHalf = 3'b001;
  localparam logic [2:0] SizeWord = 3'b010;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StData,
    StErr1,
    StErr2
  } state_e;

endpackage

// File: rtl/ahblite_sram_bytemask.sv
// Little-endian byte-lane mask from HSIZE and HADDR[1:0]; oversize transfers flag illegal
// and fall back to a full-word mask.
module ahblite_sram_bytemask
  import ahblite_pkg::*;
(
  input  logic [2:0] hsize,
  input  logic [1:0] addr_lo,
  output logic [3:0] mask,
  output logic       size_illegal
);

  always_comb begin
    mask         = 4'hF;
    size_illegal = 1'b0;
    case (hsize)
      SizeByte: mask = 4'b0001 << addr_lo;
      SizeHalf: mask = addr_lo[1] ? 4'b1100 : 4'b0011;
      SizeWord: mask = 4'hF;
      default: begin
        mask         = 4'hF;
        size_illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/ahblite_sram_slave.sv
// AHB-Lite word-organised SRAM slave with programmable wait states.
// Define AHB_SRAM_ERR_RESP_EN to answer illegal transfers with a two-cycle ERROR.
module ahblite_sram_slave
  import ahblite_pkg::*;
#(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned AW          = 10,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic [2:0]  HBURST,
  input  logic [3:0]  HPROT,
  input  logic        HWRITE,
  input  logic        HMASTLOCK,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic [1:0]  HRESP,
  output logic        HREADYOUT
);

`ifdef AHB_SRAM_ERR_RESP_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  localparam logic [3:0] WaitInit = 4'(WAIT_STATES - 1);

  logic [31:0] mem [DEPTH];

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [3:0]    mask_q, mask_d;
  logic          write_q, write_d;
  logic          drop_q, drop_d;

  logic [3:0] bus_mask;
  logic       size_bad;
  logic       out_of_range;
  logic       accept;
  logic       mem_we;
  logic       unused;

  assign unused = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};

  ahblite_sram_bytemask u_bytemask (
    .hsize       (HSIZE),
    .addr_lo     (HADDR[1:0]),
    .mask        (bus_mask),
    .size_illegal(size_bad)
  );

  // Full word address is compared so bits above the index cannot alias into range.
  assign out_of_range = (32'(HADDR[31:2]) >= DEPTH);
  assign accept       = HSEL & HREADY & HTRANS[1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    mask_d  = mask_q;
    write_d = write_q;
    drop_d  = drop_q;
    unique case (state_q)
      StIdle, StData, StErr2: begin
        // HREADY low here means another slave is stalling the bus: hold.
        if (HREADY) begin
          if (accept) begin
            addr_d  = HADDR[AW+1:2];
            mask_d  = bus_mask;
            write_d = HWRITE;
            drop_d  = out_of_range;
            if (ErrEn && (out_of_range || size_bad)) begin
              state_d = StErr1;
            end else if (WAIT_STATES == 0) begin
              state_d = StData;
            end else begin
              state_d = StWait;
              cnt_d   = WaitInit;
            end
          end else begin
            state_d = StIdle;
          end
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          state_d = StData;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StErr1:  state_d = StErr2;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      mask_q  <= '0;
      write_q <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      mask_q  <= mask_d;
      write_q <= write_d;
      drop_q  <= drop_d;
    end
  end

  assign mem_we = (state_q == StData) && write_q && !drop_q && HREADY && !HRESET;

  always_ff @(posedge HCLK) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (mask_q[i]) begin
          mem[addr_q][8*i +: 8] <= HWDATA[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = RespOkay;
    unique case (state_q)
      StWait:  HREADYOUT = 1'b0;
      StErr1: begin
        HREADYOUT = 1'b0;
        HRESP     = RespError;
      end
      StErr2:  HRESP = RespError;
      default: ;
    endcase
  end

  assign HRDATA = ((state_q == StData) && !write_q && !drop_q) ? mem[addr_q] : 32'h0;

endmodule

// File: tb/tb_ahblite_sram_slave.sv
// Directed bench: one zero-wait and one three-wait-state slave sharing a bus stimulus.
module tb_ahblite_sram_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel0, sel3;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic        hwrite;
  logic        hmastlock;
  logic        hready;
  logic [31:0] rdata0, rdata3;
  logic [1:0]  resp0, resp3;
  logic        rdy0, rdy3;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_word;

  always #5 clk = ~clk;

  ahblite_sram_slave #(.DEPTH(1024), .AW(10), .WAIT_STATES(0)) u_dut0 (
    .HCLK(clk), .HRESET(rst), .HSEL(sel0), .HADDR(haddr), .HTRANS(htrans), .HSIZE(hsize),
    .HWDATA(hwdata), .HBURST(hburst), .HPROT(hprot), .HWRITE(hwrite), .HMASTLOCK(hmastlock),
    .HREADY(hready), .HRDATA(rdata0), .HRESP(resp0), .HREADYOUT(rdy0)
  );

  ahblite_sram_slave #(.DEPTH(1024), .AW(10), .WAIT_STATES(3)) u_dut3 (
    .HCLK(clk), .HRESET(rst), .HSEL(sel3), .HADDR(haddr), .HTRANS(htrans), .HSIZE(hsize),
    .HWDATA(hwdata), .HBURST(hburst), .HPROT(hprot), .HWRITE(hwrite), .HMASTLOCK(hmastlock),
    .HREADY(hready), .HRDATA(rdata3), .HRESP(resp3), .HREADYOUT(rdy3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic addr_ph(input logic [31:0] a, input logic w, input logic [2:0] sz);
    htrans = 2'b10;
    haddr  = a;
    hwrite = w;
    hsize  = sz;
  endtask

  task automatic idle_ph();
    htrans = 2'b00;
    hwrite = 1'b0;
  endtask

  initial begin
    rst = 1'b1; sel0 = 1'b0; sel3 = 1'b0; haddr = '0; htrans = 2'b00; hsize = 3'b010;
    hwdata = '0; hburst = '0; hprot = '0; hwrite = 1'b0; hmastlock = 1'b0; hready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_rdy0", 32'(rdy0), 32'd1);
    chk("rst_resp0", 32'(resp0), 32'd0);
    chk("rst_rdata0", rdata0, 32'h0);
    chk("rst_rdy3", 32'(rdy3), 32'd1);

    // Write then read back-to-back, zero wait states
    sel0 = 1'b1;
    addr_ph(32'h10, 1'b1, 3'b010);
    tick();
    chk("wr_rdy", 32'(rdy0), 32'd1);
    hwdata = 32'hDEADBEEF;
    addr_ph(32'h10, 1'b0, 3'b010);
    tick();
    chk("rd_data", rdata0, 32'hDEADBEEF);
    chk("rd_rdy", 32'(rdy0), 32'd1);
    chk("rd_resp", 32'(resp0), 32'd0);
    idle_ph();
    tick();
    chk("idle_rdata", rdata0, 32'h0);

    // Byte and halfword lanes
    addr_ph(32'h10, 1'b1, 3'b010);
    tick();
    hwdata = 32'h11223344;
    addr_ph(32'h13, 1'b1, 3'b000);
    tick();
    hwdata = 32'hAAEEDDCC;
    addr_ph(32'h10, 1'b0, 3'b010);
    tick();
    chk("byte3", rdata0, 32'hAA223344);
    addr_ph(32'h12, 1'b1, 3'b001);
    tick();
    hwdata = 32'h55669988;
    addr_ph(32'h10, 1'b0, 3'b010);
    tick();
    chk("half_hi", rdata0, 32'h55663344);
    addr_ph(32'h11, 1'b1, 3'b000);
    tick();
    hwdata = 32'h12347756;
    addr_ph(32'h10, 1'b0, 3'b010);
    tick();
    chk("byte1", rdata0, 32'h55667744);
    addr_ph(32'h0, 1'b1, 3'b010);
    tick();
    hwdata = 32'h13579BDF;
    idle_ph();
    tick();

    // BUSY / IDLE while selected: zero-wait OKAY, no access
    htrans = 2'b01; haddr = 32'h10; hwrite = 1'b1; hwdata = 32'h0;
    tick();
    chk("busy_rdy", 32'(rdy0), 32'd1);
    chk("busy_resp", 32'(resp0), 32'd0);
    chk("busy_rdata", rdata0, 32'h0);
    htrans = 2'b00;
    tick();
    chk("idle_rdy", 32'(rdy0), 32'd1);
    addr_ph(32'h10, 1'b0, 3'b010);
    tick();
    chk("busy_nowrite", rdata0, 32'h55667744);
    idle_ph();
    tick();

    // Out-of-range read and write
    addr_ph(32'h1000, 1'b0, 3'b010);
    tick();
`ifdef AHB_SRAM_ERR_RESP_EN
    chk("oor_rd_err1_rdy", 32'(rdy0), 32'd0);
    chk("oor_rd_err1_resp", 32'(resp0), 32'd1);
    idle_ph();
    tick();
    chk("oor_rd_err2_rdy", 32'(rdy0), 32'd1);
    chk("oor_rd_err2_resp", 32'(resp0), 32'd1);
    tick();
    chk("oor_rd_after_resp", 32'(resp0), 32'd0);
`else
    chk("oor_rd_rdy", 32'(rdy0), 32'd1);
    chk("oor_rd_resp", 32'(resp0), 32'd0);
    chk("oor_rd_data", rdata0, 32'h0);
    idle_ph();
    tick();
`endif
    addr_ph(32'h1010, 1'b1, 3'b010);
    tick();
`ifdef AHB_SRAM_ERR_RESP_EN
    chk("oor_wr_err1_rdy", 32'(rdy0), 32'd0);
    chk("oor_wr_err1_resp", 32'(resp0), 32'd1);
    hwdata = 32'hFFFFFFFF;
    idle_ph();
    tick();
    tick();
`else
    chk("oor_wr_rdy", 32'(rdy0), 32'd1);
    chk("oor_wr_resp", 32'(resp0), 32'd0);
    hwdata = 32'hFFFFFFFF;
    idle_ph();
    tick();
`endif
    addr_ph(32'h10, 1'b0, 3'b010);
    tick();
    chk("oor_wr_dropped", rdata0, 32'h55667744);
    addr_ph(32'h0, 1'b0, 3'b010);
    tick();
    chk("word0", rdata0, 32'h13579BDF);
    idle_ph();
    tick();

    // Oversize HSIZE write in range
    addr_ph(32'h20, 1'b1, 3'b010);
    tick();
    hwdata = 32'h12345678;
    addr_ph(32'h20, 1'b1, 3'b011);
    tick();
`ifdef AHB_SRAM_ERR_RESP_EN
    chk("sz3_err1_rdy", 32'(rdy0), 32'd0);
    chk("sz3_err1_resp", 32'(resp0), 32'd1);
    hwdata = 32'hCAFEF00D;
    idle_ph();
    tick();
    chk("sz3_err2_resp", 32'(resp0), 32'd1);
    tick();
    exp_word = 32'h12345678;
`else
    chk("sz3_rdy", 32'(rdy0), 32'd1);
    chk("sz3_resp", 32'(resp0), 32'd0);
    hwdata = 32'hCAFEF00D;
    idle_ph();
    tick();
    exp_word = 32'hCAFEF00D;
`endif
    addr_ph(32'h20, 1'b0, 3'b010);
    tick();
    chk("sz3_data", rdata0, exp_word);
    idle_ph();
    tick();
    sel0 = 1'b0;

    // Three wait states: HREADY low in idle must not sample the address
    sel3 = 1'b1;
    addr_ph(32'h40, 1'b0, 3'b010);
    hready = 1'b0;
    tick();
    chk("nosample_rdy", 32'(rdy3), 32'd1);
    idle_ph();
    hready = 1'b1;
    tick();

    addr_ph(32'h40, 1'b1, 3'b010);
    tick();
    hready = 1'b0;
    hwdata = 32'h0BADF00D;
    addr_ph(32'h44, 1'b0, 3'b010);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("ws_wr_low%0d", i), 32'(rdy3), 32'd0);
      tick();
    end
    chk("ws_wr_data_rdy", 32'(rdy3), 32'd1);
    chk("ws_wr_data_resp", 32'(resp3), 32'd0);
    hready = 1'b1;
    addr_ph(32'h40, 1'b0, 3'b010);
    tick();
    hready = 1'b0;
    idle_ph();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("ws_rd_low%0d", i), 32'(rdy3), 32'd0);
      chk($sformatf("ws_rd_zero%0d", i), rdata3, 32'h0);
      tick();
    end
    chk("ws_rd_rdy", 32'(rdy3), 32'd1);
    chk("ws_rd_data", rdata3, 32'h0BADF00D);
    chk("ws_rd_resp", 32'(resp3), 32'd0);
    hready = 1'b1;
    tick();
    chk("ws_idle_rdata", rdata3, 32'h0);

    // Reset during the second wait cycle of a write aborts it
    addr_ph(32'h40, 1'b1, 3'b010);
    tick();
    hwdata = 32'h77777777;
    idle_ph();
    hready = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid_rdy", 32'(rdy3), 32'd1);
    chk("rstmid_resp", 32'(resp3), 32'd0);
    chk("rstmid_rdata", rdata3, 32'h0);
    hready = 1'b1;
    addr_ph(32'h40, 1'b0, 3'b010);
    tick();
    hready = 1'b0;
    idle_ph();
    tick();
    tick();
    tick();
    chk("rstmid_rdy_data", 32'(rdy3), 32'd1);
    chk("rstmid_unchanged", rdata3, 32'h0BADF00D);
    hready = 1'b1;
    tick();
    sel3 = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
